wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-end register file for the ASIP pipeline. It consumes the writeback-stage signals produced by the MEM/WB pipeline register, selects the write data, and commits it to a 32-entry register file. It serves the two decode-stage read ports with same-cycle write-through bypass. A pending-write scoreboard generates the decode stall that the MEM/WB side needs for load-use and multi-cycle producers.

## Interface
Parameters:
- N, 32, data width of registers and write data.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- wr_en_wb  in  1  writeback enable from MEM/WB.
- wd_sel_wb  in  1  write-data select: 0 = alu_result_wb, 1 = rd_wb (memory read data).
- rw_wb  in  5  destination register of writeback.
- alu_result_wb  in  N  ALU result at writeback.
- rd_wb  in  N  memory read data at writeback.
- ra1, ra2  in  5  decode read addresses.
- src_en1, src_en2  in  1  decode actually uses ra1 / ra2 (qualifies stall).
- iss_en  in  1  decode issues a register-writing instruction this cycle (only honoured when stall = 0).
- iss_rw  in  5  destination of the issuing instruction.
- rd1, rd2  out  N  read data for ra1 / ra2.
- wd_wb  out  N  selected writeback data (for EX forwarding).
- stall  out  1  decode must hold; an operand has a pending write.

## Operation
- wd_wb = wd_sel_wb ? rd_wb : alu_result_wb; combinational.
- Commit: on the rising edge with wr_en_wb = 1 and rw_wb ≠ 0, regs[rw_wb] ← wd_wb. Writes to r0 are dropped.
- Read: rdX = 0 if raX = 0.
  - Otherwise, if wr_en_wb and rw_wb = raX, rdX = wd_wb (write-through bypass).
  - Otherwise rdX = regs[raX].
- Scoreboard: 32-bit busy vector; bit 0 is always 0.
  - Set: iss_en = 1, stall = 0 and iss_rw ≠ 0 → busy[iss_rw] ← 1 at the edge.
  - Clear: wr_en_wb = 1 and rw_wb ≠ 0 → busy[rw_wb] ← 0 at the edge.
  - Set and clear of the same register in the same edge: set wins (a new producer supersedes the retiring one).
- stall = (src_en1 & pend(ra1)) | (src_en2 & pend(ra2)).
  - pend(r) = busy[r] & ¬(wr_en_wb & rw_wb = r).
  - A value retiring this cycle is bypassed and does not stall.
- wr_en_wb with busy[rw_wb] = 0 is legal: commit occurs and busy stays 0.

## Timing
- Reset (reset = 0, asynchronous): all regs = 0 and busy = 0. Consequently rd1 = rd2 = 0 and stall = 0 while reset is held and after release.
- Reset asserted mid-operation discards pending writes and scoreboard state at once. A writeback in the same cycle as reset assertion is lost.
- Write latency: a commit is visible through the bypass in the same cycle, and from regs from the next cycle on.
- rd1, rd2, wd_wb and stall are purely combinational from inputs and state; there is no registered output path.
- stall uses the pre-edge busy vector, so an issue at edge k stalls a dependent read from cycle k+1 until the writeback cycle.
- Both read ports may address the same register; each resolves independently.

## Structure
- Shared package `asip_pkg`:
  - NREGS = 32 and REG_AW = 5.
  - REG_ZERO = 5'd0.
  - WD_SEL_ALU = 1'b0 and WD_SEL_MEM = 1'b1.
- Sub-module `wb_scoreboard`: busy vector, set/clear priority and pend/stall logic.
- The top level holds the register array, the write mux and the bypass muxes.

## Test plan
- Reset, release, read r5 on ra1 → rd1 = 0, stall = 0. Hold reset low mid-run with busy[3] = 1 → busy clears and stall = 0 immediately.
- wr_en_wb = 1, wd_sel_wb = 0, rw_wb = 7, alu_result_wb = 0xDEADBEEF, ra1 = 7:
  - Same cycle: rd1 = 0xDEADBEEF.
  - Next cycle, wr_en_wb = 0: rd1 = 0xDEADBEEF.
  - With wd_sel_wb = 1 and rd_wb = 0x12345678 → rd1 = 0x12345678.
- Write r0 with 0xFFFFFFFF → ra2 = 0 reads 0, both in the same cycle and the next.
- Issue iss_rw = 9; next cycle ra1 = 9, src_en1 = 1 → stall = 1. In the writeback cycle with rw_wb = 9 → stall = 0 and rd1 = wd_wb. With src_en1 = 0 → stall = 0 throughout.
- Same edge: iss_rw = 4 and writeback rw_wb = 4 → busy[4] = 1 after the edge, and a subsequent read of r4 stalls.
- iss_en = 1 while stall = 1 with iss_rw = 6 → busy[6] stays 0.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared ASIP pipeline constants and types used by the writeback-end
// register file and its scoreboard.
package asip_pkg;

    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam logic WD_SEL_ALU = 1'b0;
    localparam logic WD_SEL_MEM = 1'b1;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [NREGS-1:0]  busy_vec_t;

    // A register is pending unless its producer is retiring (and bypassed) right now.
    function automatic logic pend(input busy_vec_t busy, input reg_addr_t r,
                                  input logic wr_en, input reg_addr_t rw);
        return busy[r] & ~(wr_en & (rw == r));
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback and decode-side bus of the register file; master drives the
// pipeline signals, slave is the register file.
interface wb_regfile_if #(parameter int N = 32);
    import asip_pkg::*;

    logic            wr_en_wb;
    logic            wd_sel_wb;
    reg_addr_t       rw_wb;
    logic [N-1:0]    alu_result_wb;
    logic [N-1:0]    rd_wb;
    reg_addr_t       ra1;
    reg_addr_t       ra2;
    logic            src_en1;
    logic            src_en2;
    logic            iss_en;
    reg_addr_t       iss_rw;
    logic [N-1:0]    rd1;
    logic [N-1:0]    rd2;
    logic [N-1:0]    wd_wb;
    logic            stall;

    modport master (
        output wr_en_wb, wd_sel_wb, rw_wb, alu_result_wb, rd_wb,
               ra1, ra2, src_en1, src_en2, iss_en, iss_rw,
        input  rd1, rd2, wd_wb, stall
    );

    modport slave (
        input  wr_en_wb, wd_sel_wb, rw_wb, alu_result_wb, rd_wb,
               ra1, ra2, src_en1, src_en2, iss_en, iss_rw,
        output rd1, rd2, wd_wb, stall
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: tracks registers with an in-flight producer and
// raises the decode stall for operands that are not yet available.
module wb_scoreboard
    import asip_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      iss_en,
    input  reg_addr_t iss_rw,
    input  logic      wr_en_wb,
    input  reg_addr_t rw_wb,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  logic      src_en1,
    input  logic      src_en2,
    output logic      stall
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;
    busy_vec_t set_s;
    busy_vec_t clr_s;
    logic      stall_s;

    // Stall decision from the pre-edge busy vector.
    always_comb begin
        stall_s = (src_en1 & pend(busy_q, ra1, wr_en_wb, rw_wb))
                | (src_en2 & pend(busy_q, ra2, wr_en_wb, rw_wb));
    end

    // Set/clear masks; set is OR-ed in after clear so a new producer wins.
    always_comb begin
        if (wr_en_wb && (rw_wb != REG_ZERO)) begin
            clr_s = busy_vec_t'(32'd1) << rw_wb;
        end else begin
            clr_s = '0;
        end
        if (iss_en && !stall_s && (iss_rw != REG_ZERO)) begin
            set_s = busy_vec_t'(32'd1) << iss_rw;
        end else begin
            set_s = '0;
        end
        busy_d = ((busy_q & ~clr_s) | set_s) & ~busy_vec_t'(32'd1);
    end

    // Busy vector state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall = stall_s;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-end register file: write-data select, 32-entry commit array and
// two decode read ports with same-cycle write-through bypass.
module wb_regfile
    import asip_pkg::*;
#(
    parameter int N = 32
)(
    input  logic         clock,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    logic [N-1:0] regs_q [NREGS];
    logic [N-1:0] wd_s;
    logic [N-1:0] rd1_s;
    logic [N-1:0] rd2_s;
    logic         commit_s;
    logic         stall_s;

    // Writeback data select and commit qualification (r0 is never written).
    always_comb begin
        if (bus.wd_sel_wb == WD_SEL_MEM) begin
            wd_s = bus.rd_wb;
        end else begin
            wd_s = bus.alu_result_wb;
        end
        commit_s = bus.wr_en_wb && (bus.rw_wb != REG_ZERO);
    end

    // Register array commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_s) begin
            regs_q[bus.rw_wb] <= wd_s;
        end
    end

    // Read ports: r0 reads zero, a retiring write is forwarded before the array.
    always_comb begin
        if (bus.ra1 == REG_ZERO) begin
            rd1_s = '0;
        end else if (bus.wr_en_wb && (bus.rw_wb == bus.ra1)) begin
            rd1_s = wd_s;
        end else begin
            rd1_s = regs_q[bus.ra1];
        end
        if (bus.ra2 == REG_ZERO) begin
            rd2_s = '0;
        end else if (bus.wr_en_wb && (bus.rw_wb == bus.ra2)) begin
            rd2_s = wd_s;
        end else begin
            rd2_s = regs_q[bus.ra2];
        end
    end

    wb_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .iss_en   (bus.iss_en),
        .iss_rw   (bus.iss_rw),
        .wr_en_wb (bus.wr_en_wb),
        .rw_wb    (bus.rw_wb),
        .ra1      (bus.ra1),
        .ra2      (bus.ra2),
        .src_en1  (bus.src_en1),
        .src_en2  (bus.src_en2),
        .stall    (stall_s)
    );

    assign bus.wd_wb = wd_s;
    assign bus.rd1   = rd1_s;
    assign bus.rd2   = rd2_s;
    assign bus.stall = stall_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array/bitmap model of the register file.
module tb_wb_regfile;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    wb_regfile_if #(.N(32)) bus ();

    wb_regfile #(.N(32)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_wd();
        return bus.wd_sel_wb ? bus.rd_wb : bus.alu_result_wb;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wr_en_wb && bus.rw_wb == a) return exp_wd();
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic p1, p2;
        p1 = m_busy[bus.ra1] && !(bus.wr_en_wb && bus.rw_wb == bus.ra1);
        p2 = m_busy[bus.ra2] && !(bus.wr_en_wb && bus.rw_wb == bus.ra2);
        return (bus.src_en1 && p1) || (bus.src_en2 && p2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.wr_en_wb = 1'b0; bus.wd_sel_wb = 1'b0; bus.rw_wb = 5'd0;
        bus.alu_result_wb = 32'd0; bus.rd_wb = 32'd0;
        bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.src_en1 = 1'b0; bus.src_en2 = 1'b0;
        bus.iss_en = 1'b0; bus.iss_rw = 5'd0;
    endtask

    // One clock edge; the model advances using the inputs present before the edge.
    task automatic tick();
        logic [31:0] wd;
        logic        st;
        wd = exp_wd();
        st = exp_stall();
        @(posedge clk);
        if (rst_n) begin
            if (bus.wr_en_wb && bus.rw_wb != 5'd0) begin
                m_regs[bus.rw_wb] = wd;
                m_busy[bus.rw_wb] = 1'b0;
            end
            if (bus.iss_en && !st && bus.iss_rw != 5'd0) m_busy[bus.iss_rw] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        bus.ra1 = 5'd5; bus.src_en1 = 1'b1; bus.ra2 = 5'd5; bus.src_en2 = 1'b1;
        #1;
        checks++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_held rd1=%h rd2=%h stall=%b required 0/0/0", bus.rd1, bus.rd2, bus.stall);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.rd1 !== 32'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rd1=%h stall=%b required 0/0", bus.rd1, bus.stall);
        end
    endtask

    task automatic test_write_bypass();
        idle();
        bus.wr_en_wb = 1'b1; bus.wd_sel_wb = 1'b0; bus.rw_wb = 5'd7;
        bus.alu_result_wb = 32'hDEADBEEF; bus.rd_wb = 32'h0BADF00D; bus.ra1 = 5'd7;
        #1;
        checks++;
        if (bus.rd1 !== 32'hDEADBEEF || bus.wd_wb !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle rd1=%h wd_wb=%h required deadbeef", bus.rd1, bus.wd_wb);
        end
        tick();
        bus.wr_en_wb = 1'b0;
        #1;
        checks++;
        if (bus.rd1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL committed_read rd1=%h required deadbeef", bus.rd1);
        end
        bus.wr_en_wb = 1'b1; bus.wd_sel_wb = 1'b1; bus.rd_wb = 32'h12345678;
        #1;
        checks++;
        if (bus.rd1 !== 32'h12345678 || bus.wd_wb !== 32'h12345678) begin
            errors++;
            $display("FAIL mem_select rd1=%h wd_wb=%h required 12345678", bus.rd1, bus.wd_wb);
        end
        tick();
        bus.wr_en_wb = 1'b0;
        #1;
        checks++;
        if (bus.rd1 !== 32'h12345678) begin
            errors++;
            $display("FAIL mem_committed rd1=%h required 12345678", bus.rd1);
        end
    endtask

    task automatic test_r0();
        idle();
        bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd0; bus.alu_result_wb = 32'hFFFFFFFF; bus.ra2 = 5'd0;
        #1;
        checks++;
        if (bus.rd2 !== 32'd0) begin
            errors++;
            $display("FAIL r0_same_cycle rd2=%h required 0", bus.rd2);
        end
        tick();
        bus.wr_en_wb = 1'b0;
        #1;
        checks++;
        if (bus.rd2 !== 32'd0) begin
            errors++;
            $display("FAIL r0_next_cycle rd2=%h required 0", bus.rd2);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.iss_en = 1'b1; bus.iss_rw = 5'd9;
        #1;
        tick();
        bus.iss_en = 1'b0; bus.ra1 = 5'd9; bus.src_en1 = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall stall=%b required 1", bus.stall);
        end
        bus.src_en1 = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL unused_src stall=%b required 0", bus.stall);
        end
        bus.src_en1 = 1'b1; bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd9; bus.alu_result_wb = 32'hCAFE0009;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd1 !== 32'hCAFE0009 || bus.rd1 !== bus.wd_wb) begin
            errors++;
            $display("FAIL retire_bypass stall=%b rd1=%h required 0/cafe0009", bus.stall, bus.rd1);
        end
        tick();
        bus.wr_en_wb = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd1 !== 32'hCAFE0009) begin
            errors++;
            $display("FAIL after_retire stall=%b rd1=%h required 0/cafe0009", bus.stall, bus.rd1);
        end
    endtask

    task automatic test_same_edge();
        idle();
        bus.iss_en = 1'b1; bus.iss_rw = 5'd4;
        bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd4; bus.alu_result_wb = 32'h44444444;
        #1;
        tick();
        idle();
        bus.ra2 = 5'd4; bus.src_en2 = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL set_wins stall=%b required 1", bus.stall);
        end
        bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd4; bus.alu_result_wb = 32'h44440004;
        #1;
        tick();
        idle();
    endtask

    task automatic test_issue_while_stalled();
        idle();
        bus.iss_en = 1'b1; bus.iss_rw = 5'd10;
        #1;
        tick();
        bus.iss_rw = 5'd6; bus.ra1 = 5'd10; bus.src_en1 = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL stalled_issue_setup stall=%b required 1", bus.stall);
        end
        tick();
        idle();
        bus.ra1 = 5'd6; bus.src_en1 = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL stalled_issue_dropped stall=%b required 0", bus.stall);
        end
        idle();
        bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd10; bus.alu_result_wb = 32'h1010;
        #1;
        tick();
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        bus.iss_en = 1'b1; bus.iss_rw = 5'd3;
        #1;
        tick();
        idle();
        bus.ra1 = 5'd3; bus.src_en1 = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup stall=%b required 1", bus.stall);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async stall=%b required 0", bus.stall);
        end
        bus.wr_en_wb = 1'b1; bus.rw_wb = 5'd7; bus.alu_result_wb = 32'h77777777;
        tick();
        idle();
        rst_n = 1'b1;
        bus.ra1 = 5'd7; bus.ra2 = 5'd3; bus.src_en2 = 1'b1;
        #1;
        checks++;
        if (bus.rd1 !== 32'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL write_lost_in_reset rd1=%h stall=%b required 0/0", bus.rd1, bus.stall);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.wr_en_wb      = ($urandom_range(0, 1) == 1);
            bus.wd_sel_wb     = ($urandom_range(0, 1) == 1);
            bus.rw_wb         = 5'($urandom_range(0, 7));
            bus.alu_result_wb = $urandom;
            bus.rd_wb         = $urandom;
            bus.ra1           = 5'($urandom_range(0, 7));
            bus.ra2           = 5'($urandom_range(0, 7));
            bus.src_en1       = ($urandom_range(0, 3) != 0);
            bus.src_en2       = ($urandom_range(0, 3) != 0);
            bus.iss_en        = ($urandom_range(0, 2) == 0);
            bus.iss_rw        = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (bus.rd1 !== exp_rd(bus.ra1) || bus.rd2 !== exp_rd(bus.ra2) ||
                bus.wd_wb !== exp_wd() || bus.stall !== exp_stall()) begin
                errors++;
                $display("FAIL random[%0d] rd1=%h/%h rd2=%h/%h wd=%h/%h stall=%b/%b (actual/required)",
                         n, bus.rd1, exp_rd(bus.ra1), bus.rd2, exp_rd(bus.ra2),
                         bus.wd_wb, exp_wd(), bus.stall, exp_stall());
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        model_clear();
        test_reset();
        test_write_bypass();
        test_r0();
        test_scoreboard();
        test_same_edge();
        test_issue_while_stalled();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
